// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts width_p-bit words over valid/ready and
// emits them MSB first on d_o, one bit per cycle with en_i=1, gapless back-to-back.
module piso_serializer #(
    parameter int unsigned width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               en_i,
    output logic               valid_o,
    output logic               d_o,
    output logic               last_o
);

    localparam int unsigned CNT_W = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width_p - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(width_p - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic               hold_v;
    logic [width_p-1:0] hold_d;
    logic [width_p-1:0] shreg;
    logic [CNT_W-1:0]   cnt;

    // ready_o mirrors ~hold_v as its own flop; outputs are updated alongside the
    // state they describe so every port comes straight from a register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            hold_v  <= 1'b0;
            hold_d  <= '0;
            shreg   <= '0;
            cnt     <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            d_o     <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            // Accept only into an empty buffer, so it never collides with a drain.
            if (valid_i && ready_o) begin
                hold_v  <= 1'b1;
                hold_d  <= data_i;
                ready_o <= 1'b0;
            end

            if (state == IDLE) begin
                if (hold_v) begin
                    state   <= SHIFT;
                    shreg   <= hold_d;
                    cnt     <= '0;
                    hold_v  <= 1'b0;
                    ready_o <= 1'b1;
                    valid_o <= 1'b1;
                    d_o     <= hold_d[width_p-1];
                    last_o  <= 1'b0;
                end
            end else if (en_i) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    if (hold_v) begin
                        // Next word follows with no bubble.
                        shreg   <= hold_d;
                        hold_v  <= 1'b0;
                        ready_o <= 1'b1;
                        d_o     <= hold_d[width_p-1];
                        last_o  <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        d_o     <= 1'b0;
                        last_o  <= 1'b0;
                    end
                end else begin
                    shreg  <= {shreg[width_p-2:0], 1'b0};
                    cnt    <= cnt + CNT_W'(1);
                    d_o    <= shreg[width_p-2];
                    last_o <= (cnt == CNT_PEN);
                end
            end
        end
    end

endmodule
